// File: rtl/button_event_encoder.sv
// button_event_encoder: synchronizes and debounces four buttons, queues press events in a FIFO.
// Define BUTTON_AUTO_REPEAT_EN to add auto-repeat press events for held A/B buttons.
module button_event_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [3:0]                    btn_raw,
    output logic [1:0]                    x,
    output logic                          x_valid,
    input  logic                          x_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    sync1_q, sync2_q, stable_q, stable_d, prev_q, pend_q, pend_d;
    logic [3:0]    press, evt, kept, push_mask;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [NW-1:0] count_q, count_d;
    logic [1:0]    code;
    logic          ovf_q, ovf_d, push, pop;

    // A level is accepted only after it has differed from the stable level for DEBOUNCE_CYCLES in a row
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            cnt_d[b] = (sync2_q[b] == stable_q[b] || cnt_q[b] == DB_LAST) ? '0 : cnt_q[b] + 1'b1;
            stable_d[b] = (sync2_q[b] != stable_q[b] && cnt_q[b] == DB_LAST) ? sync2_q[b] : stable_q[b];
        end
    end

    assign press = stable_q & ~prev_q;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);

    logic [RW-1:0] rcnt_q [2];
    logic [RW-1:0] rcnt_d [2];
    logic [1:0]    rep_q, rep_d, hit;

    // rcnt counts cycles since the last (original or repeat) event of a held A/B button
    always_comb begin
        for (int j = 0; j < 2; j++) begin
            hit[j] = stable_q[j+2] && rcnt_q[j] == (rep_q[j] ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY));
            rcnt_d[j] = !stable_q[j+2] ? '0 : (press[j+2] || hit[j]) ? RW'(1) : rcnt_q[j] + 1'b1;
            rep_d[j] = stable_q[j+2] && (rep_q[j] || hit[j]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rep_q <= '0;
            for (int j = 0; j < 2; j++) rcnt_q[j] <= '0;
        end else begin
            rep_q <= rep_d;
            for (int j = 0; j < 2; j++) rcnt_q[j] <= rcnt_d[j];
        end
    end

    assign evt = press | {hit, 2'b00};
`else
    localparam int repeat_cfg_unused = REPEAT_DELAY + REPEAT_PERIOD;

    assign evt = press;
`endif

    // Lowest-numbered pending button wins the single push slot each cycle
    always_comb begin
        code      = pend_q[0] ? 2'd0 : pend_q[1] ? 2'd1 : pend_q[2] ? 2'd2 : 2'd3;
        pop       = x_valid && x_ready;
        push      = (|pend_q) && (count_q != NW'(FIFO_DEPTH) || pop);
        push_mask = push ? 4'b0001 << code : 4'b0000;
        kept      = pend_q & ~push_mask;
        pend_d    = kept | evt;
        ovf_d     = |(kept & evt);
        count_d   = count_q + NW'(push) - NW'(pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            pend_q   <= '0;
            ovf_q    <= 1'b0;
            rd_q     <= '0;
            wr_q     <= '0;
            count_q  <= '0;
            for (int b = 0; b < 4; b++) cnt_q[b] <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            rd_q     <= rd_q + AW'(pop);
            wr_q     <= wr_q + AW'(push);
            count_q  <= count_d;
            for (int b = 0; b < 4; b++) cnt_q[b] <= cnt_d[b];
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_q] <= code;
    end

    assign x_valid    = count_q != '0;
    assign x          = x_valid ? mem_q[rd_q] : 2'd0;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_button_event_encoder.sv
// tb_button_event_encoder: directed scenarios plus randomized run against a queue-based reference model.
module tb_button_event_encoder;
    localparam int DB = 4, DEPTH = 4;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int RD = 16, RP = 8;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_raw = 4'b0;
    logic       x_ready = 1'b0;
    logic [1:0] x;
    logic       x_valid, overflow;
    logic [2:0] fifo_count;
    int errors = 0, checks = 0;

    always #5 clock = ~clock;

    button_event_encoder #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(DEPTH), .REPEAT_DELAY(16), .REPEAT_PERIOD(8)) dut (
        .clock(clock), .reset(reset), .btn_raw(btn_raw), .x(x), .x_valid(x_valid),
        .x_ready(x_ready), .overflow(overflow), .fifo_count(fifo_count)
    );

    // Reference model: a window of the last DB synchronized samples decides the stable level,
    // press ages drive repeats, and an SV queue stands in for the FIFO.
    bit [3:0] m_h1, m_h2, m_stable, m_pend, m_evt;
    bit       m_ovf;
    bit [3:0] m_win[$];
    bit [1:0] m_q[$];
    int       m_age[4];

    always @(posedge clock or posedge reset) begin : model
        bit [3:0] kept, nst, evt;
        bit pop, pushed, ovf, all_diff;
        if (reset) begin
            m_h1 = 0; m_h2 = 0; m_stable = 0; m_pend = 0; m_evt = 0; m_ovf = 0;
            m_win.delete();
            m_q.delete();
            for (int b = 0; b < 4; b++) m_age[b] = 0;
        end else begin
            pop = m_q.size() != 0 && x_ready;
            if (pop) m_q.delete(0);
            kept = m_pend;
            pushed = 0;
            if (m_q.size() < DEPTH)
                for (int b = 0; b < 4; b++)
                    if (kept[b] && !pushed) begin
                        m_q.push_back(2'(b));
                        kept[b] = 0;
                        pushed = 1;
                    end
            ovf = 0;
            for (int b = 0; b < 4; b++)
                if (m_evt[b]) begin
                    if (kept[b]) ovf = 1;
                    else kept[b] = 1;
                end
            m_pend = kept;
            m_ovf = ovf;
            m_win.push_back(m_h2);
            if (m_win.size() > DB) m_win.delete(0);
            nst = m_stable;
            if (m_win.size() == DB)
                for (int b = 0; b < 4; b++) begin
                    all_diff = 1;
                    foreach (m_win[k]) if (m_win[k][b] == m_stable[b]) all_diff = 0;
                    if (all_diff) nst[b] = ~m_stable[b];
                end
            evt = nst & ~m_stable;
            for (int b = 2; b < 4; b++) begin
                if (nst[b] && !m_stable[b]) m_age[b] = 0;
                else if (nst[b]) begin
                    m_age[b]++;
`ifdef BUTTON_AUTO_REPEAT_EN
                    if (m_age[b] == RD || (m_age[b] > RD && (m_age[b] - RD) % RP == 0)) evt[b] = 1;
`endif
                end
            end
            m_evt = evt;
            m_stable = nst;
            m_h2 = m_h1;
            m_h1 = btn_raw;
        end
    end

    task automatic test_reset();
        reset = 1; btn_raw = 0; x_ready = 0;
        repeat (3) @(negedge clock);
        checks++; if (x_valid !== 1'b0) begin errors++; $display("FAIL reset_x_valid got=%b exp=0", x_valid); end
        checks++; if (x !== 2'd0) begin errors++; $display("FAIL reset_x got=%0d exp=0", x); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        reset = 0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_single_press();
        x_ready = 1; btn_raw = 4'b0100;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clock);
            checks++;
            if (x_valid !== (i == 8)) begin errors++; $display("FAIL single_valid edge=%0d got=%b exp=%b", i, x_valid, i == 8); end
            if (i == 8) begin
                checks++; if (x !== 2'd2) begin errors++; $display("FAIL single_code got=%0d exp=2", x); end
            end
            if (i == 10) btn_raw = 0;
        end
        repeat (8) @(negedge clock);
    endtask

    task automatic test_bounce();
        bit [3:0] pat [4] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000};
        x_ready = 1;
        for (int i = 0; i < 19; i++) begin
            btn_raw = (i < 4) ? pat[i] : 4'b0000;
            @(negedge clock);
            checks++;
            if ({x_valid, overflow} !== 2'b00) begin errors++; $display("FAIL bounce cyc=%0d got valid=%b ovf=%b exp 0 0", i, x_valid, overflow); end
        end
    endtask

    task automatic fill_all_four();
        x_ready = 0; btn_raw = 4'b1111;
        repeat (8) @(negedge clock);
        btn_raw = 0;
        repeat (8) @(negedge clock);
    endtask

    task automatic test_all_four();
        fill_all_four();
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL all4_count got=%0d exp=4", fifo_count); end
        x_ready = 1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({x_valid, x} !== {1'b1, 2'(k)}) begin errors++; $display("FAIL all4_order idx=%0d got valid=%b x=%0d exp 1 %0d", k, x_valid, x, k); end
            @(negedge clock);
        end
        checks++; if (x_valid !== 1'b0) begin errors++; $display("FAIL all4_drained got=%b exp=0", x_valid); end
    endtask

    task automatic test_overflow();
        int ovf_seen = 0;
        bit count_ok = 1;
        bit [1:0] exp_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
        fill_all_four();
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_fill got=%0d exp=4", fifo_count); end
        for (int i = 0; i < 32; i++) begin
            btn_raw = ((i % 16) < 6) ? 4'b0100 : 4'b0000;
            @(negedge clock);
            ovf_seen += overflow;
            if (fifo_count !== 3'd4) count_ok = 0;
        end
        checks++; if (ovf_seen != 1) begin errors++; $display("FAIL ovf_pulses got=%0d exp=1", ovf_seen); end
        checks++; if (!count_ok) begin errors++; $display("FAIL ovf_count_held got=changed exp=stay 4"); end
        x_ready = 1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({x_valid, x} !== {1'b1, exp_seq[k]}) begin errors++; $display("FAIL ovf_drain idx=%0d got valid=%b x=%0d exp 1 %0d", k, x_valid, x, exp_seq[k]); end
            @(negedge clock);
        end
        checks++; if (x_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b exp=0", x_valid); end
    endtask

    task automatic test_hold();
        int exp_t[$];
        int got_t[$];
        bit code_ok = 1;
`ifdef BUTTON_AUTO_REPEAT_EN
        exp_t = '{8, 24, 32, 40};
`else
        exp_t = '{8};
`endif
        x_ready = 1; btn_raw = 4'b0100;
        for (int i = 1; i <= 75; i++) begin
            @(negedge clock);
            if (x_valid) begin
                got_t.push_back(i);
                if (x !== 2'd2) code_ok = 0;
            end
            if (i == 40) btn_raw = 0;
        end
        checks++; if (got_t.size() != exp_t.size()) begin errors++; $display("FAIL hold_events got=%0d exp=%0d", got_t.size(), exp_t.size()); end
        checks++; if (!code_ok) begin errors++; $display("FAIL hold_code got=non-A exp=2"); end
        for (int k = 0; k < exp_t.size() && k < got_t.size(); k++) begin
            checks++;
            if (got_t[k] != exp_t[k]) begin errors++; $display("FAIL hold_time idx=%0d got=%0d exp=%0d", k, got_t[k], exp_t[k]); end
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        x_ready = 0; btn_raw = 4'b1101;
        repeat (6) @(negedge clock);
        btn_raw = 0;
        repeat (10) @(negedge clock);
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL mid_pre_count got=%0d exp=3", fifo_count); end
        btn_raw = 4'b0010;
        repeat (7) @(negedge clock);
        btn_raw = 0; reset = 1;
        #1;
        checks++; if ({x_valid, fifo_count, overflow} !== 5'b0) begin errors++; $display("FAIL mid_reset got valid=%b count=%0d ovf=%b exp 0 0 0", x_valid, fifo_count, overflow); end
        repeat (2) @(negedge clock);
        reset = 0;
        repeat (25) begin
            @(negedge clock);
            if (x_valid) seen = 1;
        end
        checks++; if (seen) begin errors++; $display("FAIL mid_no_events got=event exp=none"); end
        btn_raw = 4'b1000; reset = 1;
        repeat (3) @(negedge clock);
        reset = 0;
        repeat (10) @(negedge clock);
        btn_raw = 0;
        repeat (15) @(negedge clock);
        checks++; if ({fifo_count, x} !== {3'd1, 2'd3}) begin errors++; $display("FAIL held_reset got count=%0d x=%0d exp 1 3", fifo_count, x); end
        x_ready = 1;
        repeat (2) @(negedge clock);
        checks++; if (x_valid !== 1'b0) begin errors++; $display("FAIL held_reset_drain got=%b exp=0", x_valid); end
    endtask

    task automatic test_random();
        int left[4] = '{0, 0, 0, 0};
        logic [6:0] exp_v;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clock);
            exp_v = {m_q.size() != 0, (m_q.size() != 0) ? m_q[0] : 2'd0, 3'(m_q.size()), m_ovf};
            checks++;
            if ({x_valid, x, fifo_count, overflow} !== exp_v) begin
                errors++;
                $display("FAIL random cyc=%0d got v=%b x=%0d cnt=%0d ovf=%b exp v=%b x=%0d cnt=%0d ovf=%b",
                         c, x_valid, x, fifo_count, overflow, exp_v[6], exp_v[5:4], exp_v[3:1], exp_v[0]);
            end
            reset = (c % 500 == 499);
            for (int b = 0; b < 4; b++) begin
                if (left[b] == 0) begin
                    btn_raw[b] = ~btn_raw[b];
                    left[b] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
                end else left[b]--;
            end
            x_ready = ((c / 120) % 2 == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 2);
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_all_four();
        test_overflow();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
